// File: rtl/counter_stream_checker_pkg.sv
// counter_stream_checker_pkg: shared state encoding and parameter defaults
package counter_stream_checker_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} chk_state_e;
  localparam int WIDTH_D = 8;
  localparam int STEP_D = 1;
  localparam int LOCK_CNT_D = 4;
  localparam int MISS_MAX_D = 2;
endpackage

// File: rtl/counter_stream_checker_sat_counter.sv
// sat_counter: saturating up-counter with priority clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + W'(1);
endmodule

// File: rtl/counter_stream_checker.sv
// counter_stream_checker: locks onto a free-running counter tap and flags mismatches, lock loss and wraps
module counter_stream_checker
  import counter_stream_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int STEP = STEP_D,
  parameter int LOCK_CNT = LOCK_CNT_D,
  parameter int MISS_MAX = MISS_MAX_D,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] counter_value,
  output logic             locked,
  output logic             mismatch,
  output logic             lost,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      wrap_count
);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  chk_state_e r_state, w_state_n;
  logic [3:0] r_match_cnt, w_match_n, r_miss_cnt, w_miss_n;
  logic [WIDTH-1:0] r_expected, w_exp_n, r_prev;
  logic [15:0] r_wrap_count;
  logic r_mismatch, w_match, w_mis, w_wrap;
  assign w_match = counter_value == r_expected;
  always_comb begin
    w_state_n = r_state;
    w_match_n = r_match_cnt;
    w_miss_n = r_miss_cnt;
    w_exp_n = counter_value + STEP_V;
    w_mis = 1'b0;
    w_wrap = 1'b0;
    if (!enable) begin
      w_state_n = IDLE;
      w_match_n = '0;
      w_miss_n = '0;
    end else begin
      case (r_state)
        IDLE, LOST: begin
          w_state_n = ACQUIRE;
          w_match_n = '0;
          w_miss_n = '0;
        end
        ACQUIRE: begin
          w_match_n = w_match ? r_match_cnt + 4'd1 : '0;
          w_exp_n = w_match ? r_expected + STEP_V : counter_value + STEP_V;
          w_miss_n = '0;
          if (w_match && r_match_cnt == 4'(LOCK_CNT - 1)) w_state_n = LOCKED;
        end
        LOCKED: begin
          // free-running prediction: a lone bad sample costs one mismatch only
          w_exp_n = r_expected + STEP_V;
          w_mis = !w_match;
          w_wrap = w_match && counter_value < r_prev;
          w_miss_n = w_match ? '0 : r_miss_cnt + 4'd1;
          if (!w_match && r_miss_cnt == 4'(MISS_MAX - 1)) w_state_n = LOST;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_match_cnt <= '0;
      r_miss_cnt <= '0;
      r_expected <= '0;
      r_prev <= '0;
      r_mismatch <= 1'b0;
      r_wrap_count <= '0;
    end else begin
      r_state <= w_state_n;
      r_match_cnt <= w_match_n;
      r_miss_cnt <= w_miss_n;
      r_expected <= w_exp_n;
      r_prev <= counter_value;
      r_mismatch <= w_mis;
      r_wrap_count <= clear ? '0 : r_wrap_count + 16'(w_wrap);
    end
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk),
    .rst(rst),
    .inc(w_mis),
    .clr(clear),
    .q(err_count)
  );
  assign locked = r_state == LOCKED;
  assign lost = r_state == LOST;
  assign mismatch = r_mismatch;
  assign expected = r_expected;
  assign wrap_count = r_wrap_count;
endmodule

// File: tb/tb_counter_stream_checker.sv
// tb_counter_stream_checker: directed checks of lock, glitch, jump, wrap, clear, saturation and reset
module tb_counter_stream_checker;
  logic clk = 0, rst = 0, en = 0, en2 = 0, clr = 0;
  logic [7:0] cv = 0;
  logic lk0, mm0, ls0, lk1, mm1, ls1, lk2, mm2, ls2;
  logic [7:0] ex0, ex1, ex2;
  logic [15:0] er0, er2, wr0, wr1, wr2;
  logic [1:0] er1;
  int checks = 0, failures = 0, bad;
  logic [7:0] v;
  always #5 clk = ~clk;
  counter_stream_checker u0 (
    .clk(clk), .rst(rst), .enable(en), .clear(clr), .counter_value(cv),
    .locked(lk0), .mismatch(mm0), .lost(ls0), .expected(ex0), .err_count(er0), .wrap_count(wr0)
  );
  counter_stream_checker #(.ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .enable(en), .clear(clr), .counter_value(cv),
    .locked(lk1), .mismatch(mm1), .lost(ls1), .expected(ex1), .err_count(er1), .wrap_count(wr1)
  );
  counter_stream_checker #(.STEP(3)) u2 (
    .clk(clk), .rst(rst), .enable(en2), .clear(clr), .counter_value(cv),
    .locked(lk2), .mismatch(mm2), .lost(ls2), .expected(ex2), .err_count(er2), .wrap_count(wr2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic [7:0] val);
    cv = val;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst = 1;
    #1;
    chk("rst_locked", lk0, 0);
    chk("rst_mismatch", mm0, 0);
    chk("rst_lost", ls0, 0);
    chk("rst_expected", ex0, 0);
    chk("rst_err", er0, 0);
    chk("rst_wrap", wr0, 0);
    @(posedge clk);
    #1 rst = 0;
    en = 1;
    tick(8'h10);
    chk("acq_locked", lk0, 0);
    chk("acq_expected", ex0, 8'h11);
    tick(8'h11); tick(8'h12); tick(8'h13);
    chk("lock_edge3", lk0, 0);
    tick(8'h14);
    chk("lock_edge4", lk0, 1);
    chk("lock_expected", ex0, 8'h15);
    bad = 0;
    for (int i = 8'h15; i <= 8'h1F; i++) begin
      tick(8'(i));
      if (mm0 || !lk0) bad++;
    end
    chk("clean_run", bad, 0);
    chk("clean_err", er0, 0);
    tick(8'h55);
    chk("glitch_mm", mm0, 1);
    chk("glitch_err", er0, 1);
    chk("glitch_locked", lk0, 1);
    tick(8'h21);
    chk("glitch_mm_end", mm0, 0);
    chk("glitch_lost", ls0, 0);
    chk("glitch_hold", lk0, 1);
    for (int i = 8'h22; i <= 8'h2F; i++) tick(8'(i));
    clr = 1;
    tick(8'h30);
    clr = 0;
    chk("clear_err", er0, 0);
    chk("clear_wrap", wr0, 0);
    chk("clear_locked", lk0, 1);
    tick(8'h90);
    chk("jump_mm1", mm0, 1);
    chk("jump_err1", er0, 1);
    chk("jump_lk1", lk0, 1);
    tick(8'h91);
    chk("jump_mm2", mm0, 1);
    chk("jump_err2", er0, 2);
    chk("jump_lost", ls0, 1);
    chk("jump_unlock", lk0, 0);
    tick(8'h92);
    chk("lost_pulse_end", ls0, 0);
    chk("lost_mm_end", mm0, 0);
    chk("lost_expected", ex0, 8'h93);
    tick(8'h93); tick(8'h94); tick(8'h95);
    chk("relock_early", lk0, 0);
    tick(8'h96);
    chk("relock", lk0, 1);
    chk("relock_expected", ex0, 8'h97);
    chk("relock_err", er1, 2);
    bad = 0;
    for (int i = 8'h97; i <= 8'hFF; i++) begin
      tick(8'(i));
      if (mm0) bad++;
    end
    chk("wrap_pre", wr0, 0);
    tick(8'h00);
    chk("wrap_cnt", wr0, 1);
    tick(8'h01);
    chk("wrap_run_mm", bad + int'(mm0), 0);
    chk("wrap_err", er0, 2);
    chk("wrap_expected", ex0, 8'h02);
    en = 0;
    tick(8'h02);
    chk("dis_locked", lk0, 0);
    chk("dis_expected", ex0, 8'h03);
    chk("dis_err", er0, 2);
    chk("dis_wrap", wr0, 1);
    en = 1;
    tick(8'h03); tick(8'h04); tick(8'h05); tick(8'h06);
    chk("en_relock_early", lk0, 0);
    tick(8'h07);
    chk("en_relock", lk0, 1);
    #3 rst = 1;
    #1;
    chk("arst_locked", lk0, 0);
    chk("arst_expected", ex0, 0);
    chk("arst_err", er0, 0);
    chk("arst_wrap", wr0, 0);
    chk("arst_err_w2", er1, 0);
    @(posedge clk);
    #1 rst = 0;
    tick(8'h40); tick(8'h41); tick(8'h42); tick(8'h43); tick(8'h44);
    chk("sat_locked", lk1, 1);
    v = 8'h45;
    for (int k = 0; k < 5; k++) begin
      tick(8'h05);
      chk("sat_mm", mm1, 1);
      v = v + 8'd1;
      tick(v);
      v = v + 8'd1;
    end
    chk("sat_err_w2", er1, 3);
    chk("sat_err_w16", er0, 5);
    chk("sat_hold", lk1, 1);
    chk("sat_wrap", wr0, 0);
    clr = 1;
    tick(8'h05);
    clr = 0;
    chk("clr_win_w2", er1, 0);
    chk("clr_win_w16", er0, 0);
    chk("clr_win_mm", mm1, 1);
    en2 = 1;
    tick(8'hF1);
    chk("s3_expected", ex2, 8'hF4);
    tick(8'hF4); tick(8'hF7); tick(8'hFA);
    chk("s3_early", lk2, 0);
    tick(8'hFD);
    chk("s3_locked", lk2, 1);
    chk("s3_wrap_pre", wr2, 0);
    tick(8'h00);
    chk("s3_wrap", wr2, 1);
    chk("s3_mm", mm2, 0);
    chk("s3_expected2", ex2, 8'h03);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_stream_checker.md
# counter_stream_checker

Receive-side checker for a free-running counter exported across the hierarchy, such as an 8-bit counter value routed up from a leaf module to the top. It samples the counter every clock and predicts the next value. It locks once the sequence is consistent, then reports mismatches, loss of lock and wrap-arounds. It sits at the consuming end of the path, normally in the top or a mid-level module, and turns a raw counter tap into qualified status.

## Interface
- `WIDTH`, 8: counter width.
- `STEP`, 1: expected increment per clock, modulo 2^WIDTH.
- `LOCK_CNT`, 4: consecutive matches needed to lock (1..15).
- `MISS_MAX`, 2: consecutive misses that drop lock (1..15).
- `ERR_W`, 16: error counter width.
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  checking enabled; low forces IDLE.
- `clear`  in  1  synchronous clear of `err_count` and `wrap_count`.
- `counter_value`  in  WIDTH  observed counter tap.
- `locked`  out  1  high while in LOCKED.
- `mismatch`  out  1  one-cycle pulse per mismatch while LOCKED.
- `lost`  out  1  one-cycle pulse on lock loss.
- `expected`  out  WIDTH  current prediction.
- `err_count`  out  ERR_W  saturating count of LOCKED mismatches.
- `wrap_count`  out  16  modulo count of observed wraps while LOCKED.

## Operation
- Reset values: all outputs 0; state IDLE; internal match/miss counters 0.
- **IDLE**: `expected <= counter_value + STEP` every cycle. If `enable`=1, go to ACQUIRE with `match_cnt`=0.
- **ACQUIRE**:
  - On a match (`counter_value == expected`): `match_cnt++` and `expected += STEP`.
  - On a miss: `match_cnt <= 0` and `expected <= counter_value + STEP`.
  - When `match_cnt` reaches `LOCK_CNT`, go to LOCKED. No mismatch pulses or error counts are produced in this state.
- **LOCKED**:
  - `expected` always advances by `STEP`. It is not resynced to the sample, so a single corrupted sample costs exactly one mismatch.
  - On a miss: `mismatch`=1, `err_count++` (saturates at all-ones) and `miss_cnt++`.
  - On a match: `miss_cnt <= 0`.
  - When `miss_cnt` reaches `MISS_MAX`, go to LOST.
- **LOST**: one cycle only. `lost`=1, `locked`=0, `expected <= counter_value + STEP`, then go to ACQUIRE with `match_cnt`=0.
- **Wrap detection**: in LOCKED, a matching sample that is numerically smaller than the previous sample increments `wrap_count`, modulo 2^16. Mismatching samples never count as wraps.
- **Disable**: `enable`=0 in any state goes to IDLE on the next edge. `locked` drops on that same edge. `err_count` and `wrap_count` are retained.
- **Clear**:
  - `clear`=1 zeroes `err_count` and `wrap_count` on the next edge. State and lock are unaffected.
  - If `clear` and an increment occur in the same cycle, clear wins and the result is 0.
- **Reset mid-operation**: everything returns to reset values immediately, without waiting for a clock edge.
- **Arithmetic**: all `expected` arithmetic is modulo 2^WIDTH. Comparisons are unsigned.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- `mismatch` is asserted in the cycle after the edge that sampled the bad value.
- Lock latency on a clean source: `enable` sampled high at edge 0, then matches at edges 1..`LOCK_CNT`, so `locked`=1 after edge `LOCK_CNT` (4 by default).
- Unlock latency: `lost` pulses after the edge that samples the `MISS_MAX`-th consecutive miss. `locked` falls on that same edge.
- Re-lock after `lost`: at least `LOCK_CNT`+1 edges.

## Structure
- **Package `counter_stream_checker_pkg`**:
  - `typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} chk_state_e`.
  - Localparam defaults for `WIDTH`, `STEP`, `LOCK_CNT` and `MISS_MAX`.
- **Sub-module `sat_counter`**: parameter `W`; inputs `inc` and `clr`; output `q`. It saturates at all-ones and `clr` has priority. It is instantiated for `err_count`.
- The checker itself holds a single FSM with its match/miss counters, the `expected` register and a previous-sample register.

## Test plan
- **Clean lock**: source counts 8'h10, 8'h11, ... from reset release; `enable`=1. Expect `locked`=1 after edge 4, `mismatch` never asserted, `err_count`=0.
- **Single glitch**: when locked, force one sample 8'h55 in place of 8'h20, then resume 8'h21. Expect exactly one `mismatch` pulse, `err_count`=1, `locked` held, no `lost`.
- **Jump**: when locked at 8'h30, the source jumps to 8'h90 and continues counting. Expect two `mismatch` pulses, `err_count`=2, a `lost` pulse, then `locked` again 5 edges later with `expected` tracking 8'h9x.
- **Wrap**: locked counter passes 8'hFE, 8'hFF, 8'h00, 8'h01. Expect `wrap_count`=1 and no mismatch. With `STEP`=3, sequence 8'hFD, 8'h00 also gives `wrap_count`=1.
- **Clear/saturate**: with `ERR_W`=2, inject 5 isolated glitches. Expect `err_count`=3 (saturated). Then assert `clear` in the same cycle as a 6th glitch; expect `err_count`=0.
- **Reset/disable mid-operation**: when locked, drop `enable` for 1 cycle. Expect `locked`=0 on the next edge, counts retained, and relock after 5 edges. Then assert `rst` asynchronously between edges; expect all outputs 0 immediately.
